// File: rtl/vc_output_scheduler_pkg.sv
// vc_output_scheduler_pkg: shared sizes, FSM states and one-hot decode for the output VC scheduler
package vc_output_scheduler_pkg;
  localparam int NUM_VCS = 4;
  localparam int CREDITS_PER_VC = 16;
  localparam int CRED_W = $clog2(CREDITS_PER_VC + 1);
  localparam int VC_IDX_W = $clog2(NUM_VCS);
  typedef enum logic {IDLE, LOCKED} sched_state_e;
  function automatic logic [VC_IDX_W-1:0] onehot_to_idx(input logic [0:NUM_VCS-1] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_VCS; i++) if (oh[i]) onehot_to_idx = VC_IDX_W'(i);
  endfunction
endpackage

// File: rtl/vc_output_scheduler_rr_arbiter.sv
// vc_output_scheduler_rr_arbiter: rotating-priority arbiter, highest priority at ptr_i
module vc_output_scheduler_rr_arbiter #(
  parameter int N = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [0:N-1]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [0:N-1]     gnt_o
);
  logic [IDX_W-1:0] idx;
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_o = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler: credit-tracked wormhole VC scheduler with round-robin packet arbitration; VC_SCHED_ERR_CAPTURE_EN enables the sticky error flag
module vc_output_scheduler
  import vc_output_scheduler_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:NUM_VCS-1]         req_valid,
  input  logic [0:NUM_VCS-1]         req_head,
  input  logic [0:NUM_VCS-1]         req_tail,
  output logic [0:NUM_VCS-1]         gnt,
  output logic                       out_valid,
  output logic [0:VC_IDX_W-1]        out_vc,
  input  logic                       cred_valid,
  input  logic [0:VC_IDX_W-1]        cred_vc,
  output logic [0:NUM_VCS*CRED_W-1]  credits_avail,
  output logic                       error
);
  sched_state_e state_q, state_d;
  logic [VC_IDX_W-1:0] owner_q, owner_d, rr_q, rr_d, gnt_idx, cvc, out_vc_q;
  logic [CRED_W-1:0] cred_q [NUM_VCS];
  logic [CRED_W-1:0] cred_d [NUM_VCS];
  logic [0:NUM_VCS-1] elig, arb_req, arb_gnt, owner_oh, ovf;
  logic gnt_any, gnt_tail, bad_vc, out_valid_q;
  assign cvc = cred_vc;
  assign bad_vc = cred_valid && int'(cvc) >= NUM_VCS;
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    logic inc;
    assign elig[v] = req_valid[v] && cred_q[v] != '0;
    assign inc = cred_valid && !bad_vc && cvc == VC_IDX_W'(v);
    assign ovf[v] = inc && !gnt[v] && cred_q[v] == CRED_W'(CREDITS_PER_VC);
    assign cred_d[v] = (inc == gnt[v] || ovf[v]) ? cred_q[v] : inc ? cred_q[v] + 1'b1 : cred_q[v] - 1'b1;
    assign credits_avail[v*CRED_W +: CRED_W] = cred_q[v];
  end
  assign arb_req = (state_q == IDLE) ? elig & req_head : '0;
  vc_output_scheduler_rr_arbiter #(.N(NUM_VCS)) u_arb (
    .req_i (arb_req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      out_valid_q <= 1'b0;
      out_vc_q <= '0;
      for (int i = 0; i < NUM_VCS; i++) cred_q[i] <= CRED_W'(CREDITS_PER_VC);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      out_valid_q <= gnt_any;
      out_vc_q <= gnt_idx;
      cred_q <= cred_d;
    end
  end
  always_comb begin
    state_d = !gnt_any ? state_q : gnt_tail ? IDLE : LOCKED;
    owner_d = (gnt_any && state_q == IDLE) ? gnt_idx : owner_q;
    rr_d = gnt_tail ? ((gnt_idx == VC_IDX_W'(NUM_VCS - 1)) ? '0 : gnt_idx + 1'b1) : rr_q;
  end
  // While locked only the owner may move, and only if it has a flit and a credit.
  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    gnt = !reset ? '0 : (state_q == IDLE) ? arb_gnt : owner_oh & elig;
  end
  assign gnt_any = |gnt;
  assign gnt_idx = onehot_to_idx(gnt);
  assign gnt_tail = gnt_any && req_tail[gnt_idx];
  assign out_valid = out_valid_q;
  assign out_vc = out_vc_q;
`ifdef VC_SCHED_ERR_CAPTURE_EN
  logic err_q, head_in_lock;
  assign head_in_lock = state_q == LOCKED && req_valid[owner_q] && req_head[owner_q];
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else if (|ovf || bad_vc || head_in_lock) err_q <= 1'b1;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_vc_output_scheduler.sv
// tb_vc_output_scheduler: directed checks of arbitration, packet locking, credits and reset
module tb_vc_output_scheduler;
  import vc_output_scheduler_pkg::*;
`ifdef VC_SCHED_ERR_CAPTURE_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [0:NUM_VCS-1] req_valid, req_head, req_tail, gnt;
  logic out_valid, cred_valid, error;
  logic [0:VC_IDX_W-1] out_vc, cred_vc;
  logic [0:NUM_VCS*CRED_W-1] credits_avail;
  int checks = 0;
  int failures = 0;

  vc_output_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_head      (req_head),
    .req_tail      (req_tail),
    .gnt           (gnt),
    .out_valid     (out_valid),
    .out_vc        (out_vc),
    .cred_valid    (cred_valid),
    .cred_vc       (cred_vc),
    .credits_avail (credits_avail),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t);
    req_valid = v;
    req_head = h;
    req_tail = t;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  initial begin
    reset = 1'b0;
    cred_valid = 1'b0;
    cred_vc = '0;
    req(4'b1111, 4'b1111, 4'b1111);
    chk("gnt_in_reset", 32'(gnt), 32'b0000);
    cyc();
    cyc();
    reset = 1'b1;
    req(4'b0000, 4'b0000, 4'b0000);
    chk("rst_credits", 32'(credits_avail), 32'(pk(16, 16, 16, 16)));
    chk("rst_gnt", 32'(gnt), 32'b0000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    // Two single-flit streams alternate.
    req(4'b1010, 4'b1010, 4'b1010);
    chk("rr_g0", 32'(gnt), 32'b1000);
    cyc();
    chk("rr_ov0", 32'(out_valid), 32'd1);
    chk("rr_vc0", 32'(out_vc), 32'd0);
    chk("rr_g1", 32'(gnt), 32'b0010);
    cyc();
    chk("rr_vc1", 32'(out_vc), 32'd2);
    chk("rr_g2", 32'(gnt), 32'b1000);
    cyc();
    chk("rr_vc2", 32'(out_vc), 32'd0);
    req(4'b0000, 4'b0000, 4'b0000);
    cyc();
    chk("rr_ov_idle", 32'(out_valid), 32'd0);
    chk("rr_credits", 32'(credits_avail), 32'(pk(14, 16, 15, 16)));
    // VC1 four-flit packet with a mid-packet bubble; VC3 waits on its head.
    req(4'b0101, 4'b0101, 4'b0000);
    chk("lk_head", 32'(gnt), 32'b0100);
    cyc();
    req(4'b0101, 4'b0001, 4'b0000);
    chk("lk_body1", 32'(gnt), 32'b0100);
    cyc();
    req(4'b0001, 4'b0001, 4'b0000);
    chk("lk_bubble", 32'(gnt), 32'b0000);
    cyc();
    chk("lk_bubble_ov", 32'(out_valid), 32'd0);
    req(4'b0101, 4'b0001, 4'b0000);
    chk("lk_body2", 32'(gnt), 32'b0100);
    cyc();
    req(4'b0101, 4'b0001, 4'b0100);
    chk("lk_tail", 32'(gnt), 32'b0100);
    cyc();
    chk("lk_tail_vc", 32'(out_vc), 32'd1);
    req(4'b0001, 4'b0001, 4'b0001);
    chk("lk_vc3", 32'(gnt), 32'b0001);
    cyc();
    chk("lk_vc3_out", 32'(out_vc), 32'd3);
    req(4'b0000, 4'b0000, 4'b0000);
    chk("lk_credits", 32'(credits_avail), 32'(pk(14, 12, 15, 15)));
    // Exhaust VC0 credits, then return one.
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    req(4'b1000, 4'b1000, 4'b1000);
    for (int i = 0; i < CREDITS_PER_VC; i++) begin
      chk($sformatf("cr_g%0d", i), 32'(gnt), 32'b1000);
      cyc();
    end
    chk("cr_empty", 32'(credits_avail), 32'(pk(0, 16, 16, 16)));
    chk("cr_17th", 32'(gnt), 32'b0000);
    cyc();
    chk("cr_17th_ov", 32'(out_valid), 32'd0);
    cred_valid = 1'b1;
    cred_vc = 2'd0;
    #1;
    chk("cr_ret_same", 32'(gnt), 32'b0000);
    cyc();
    cred_valid = 1'b0;
    #1;
    chk("cr_ret_count", 32'(credits_avail), 32'(pk(1, 16, 16, 16)));
    chk("cr_ret_next", 32'(gnt), 32'b1000);
    cyc();
    chk("cr_ret_ov", 32'(out_valid), 32'd1);
    chk("cr_after", 32'(credits_avail), 32'(pk(0, 16, 16, 16)));
    // VC2 down to 5, then simultaneous grant and return.
    req(4'b0010, 4'b0010, 4'b0010);
    for (int i = 0; i < 11; i++) cyc();
    chk("c5_count", 32'(credits_avail), 32'(pk(0, 16, 5, 16)));
    cred_valid = 1'b1;
    cred_vc = 2'd2;
    #1;
    chk("c5_gnt", 32'(gnt), 32'b0010);
    cyc();
    chk("c5_same", 32'(credits_avail), 32'(pk(0, 16, 5, 16)));
    chk("c5_no_err", 32'(error), 32'd0);
    req(4'b0000, 4'b0000, 4'b0000);
    cred_vc = 2'd3;
    cyc();
    cred_valid = 1'b0;
    #1;
    chk("ovf_sat", 32'(credits_avail), 32'(pk(0, 16, 5, 16)));
    chk("ovf_err", 32'(error), 32'(ERR_EXP));
    // Reset in the middle of a VC1 packet.
    req(4'b0100, 4'b0100, 4'b0000);
    chk("rl_head", 32'(gnt), 32'b0100);
    cyc();
    reset = 1'b0;
    req(4'b0101, 4'b0001, 4'b0000);
    chk("rl_gnt_rst", 32'(gnt), 32'b0000);
    cyc();
    reset = 1'b1;
    #1;
    chk("rl_vc3", 32'(gnt), 32'b0001);
    chk("rl_credits", 32'(credits_avail), 32'(pk(16, 16, 16, 16)));
    chk("rl_error", 32'(error), 32'd0);
    cyc();
    chk("rl_out_vc", 32'(out_vc), 32'd3);
    req(4'b0000, 4'b0000, 4'b0000);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
